axil2wb_master: RTL and testbench
=================================

Name: axil2wb_master

Overview:
- AXI-Lite slave to Wishbone classic master bridge. It lets an AXI-Lite initiator (firmware test harness, host-side agent) reach Wishbone targets in the user project area, such as the FIR wrapper at 0x3000_0000.
- It accepts one write (AW+W) and one read (AR) at a time and converts each into a single Wishbone cycle.
- It returns the B/R response with OKAY or SLVERR status, and aborts any Wishbone cycle that does not complete within a timeout.

Parameters:
- ADDR_BASE, 32'h3000_0000, Wishbone base address; bits [11:0] must be zero.
- AW, 12, AXI-Lite address width.
- TIMEOUT, 255, maximum wait cycles for ack/err before abort; range 1..2^TO_W-1.
- TO_W, 8, timeout counter width.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  AW  write byte address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  AW  read byte address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  32  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- wbm_cyc_o  out  1  WB cycle
- wbm_stb_o  out  1  WB strobe
- wbm_we_o  out  1  WB write enable
- wbm_sel_o  out  4  WB byte select
- wbm_adr_o  out  32  WB address
- wbm_dat_o  out  32  WB write data
- wbm_dat_i  in  32  WB read data
- wbm_ack_i  in  1  WB ack
- wbm_err_i  in  1  WB error

Behaviour:
- Clock and reset: clock wb_clk_i; reset wb_rst_i, asynchronous, active-high. All outputs are registered.
- Reset values:
  - All outputs are 0, including awready, wready and arready.
  - awready, wready and arready rise on the first clock edge after reset deassertion.
- Capture:
  - AW, W and AR are each latched into a holding register with a held flag.
  - awready = !aw_held, wready = !w_held, arready = !ar_held, each registered.
  - Every ready drops the edge after its handshake. AW and W may arrive in either order or in the same cycle.
  - A held flag clears on completion of the matching B (aw/w) or R (ar) handshake. Each ready re-asserts the following edge.
- FSM states: IDLE, WB_WR, WB_RD, B_RSP, R_RSP.
- IDLE:
  - Write pending = aw_held & w_held. Read pending = ar_held.
  - If only one is pending, grant it.
  - If both are pending, grant the opposite of the last grant; the last grant resets to "read", so write wins first.
  - On grant, at the next edge: cyc=stb=1, adr=ADDR_BASE|addr, we=1 for write, sel=wstrb for write / 4'hF for read, dat_o=wdata. The timeout counter clears.
- WB_WR / WB_RD:
  - Hold cyc, stb and all fields stable. The counter increments each cycle.
  - On ack: cyc=stb=0 at that edge; resp=OKAY; rdata=wbm_dat_i for reads.
  - On err (err has priority over ack if both): cyc=stb=0; resp=SLVERR; rdata=0.
  - Counter == TIMEOUT with no ack/err: cyc=stb=0; resp=SLVERR; rdata=0.
  - Then go to B_RSP or R_RSP with bvalid or rvalid=1.
- B_RSP / R_RSP:
  - Hold valid until bready/rready is sampled high. Clear valid, bresp/rresp and the held flag, then return to IDLE.
  - The next Wishbone cycle can start at the earliest one edge after IDLE is entered.
- Latency: the minimum write is AW+W handshake at edge N, cyc high from N+1, ack at N+1, bvalid high from N+2.
- Edge cases:
  - wbm_sel_o=0 (wstrb=0) is still issued as a WB write.
  - A late ack arriving after a timeout is ignored.
  - A new AW/W/AR arriving during a response is held; it never changes an in-flight Wishbone cycle.
  - Reset asserted mid-cycle drops cyc/stb immediately (asynchronously) and discards pending requests.

Decomposition:
- Shared package axil_wb_pkg holds:
  - FSM state encoding.
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Default ADDR_BASE.
- One natural sub-module, axil_hold_reg: valid/ready capture register with held flag and clear input, instantiated for AW, W and AR.

Test Plan:
1. Write awaddr=0x010, wdata=0xDEADBEEF, wstrb=F, target acks after 2 cycles -> WB adr=0x3000_0010, we=1, sel=F, dat_o=0xDEADBEEF; bvalid with bresp=00.
2. Read araddr=0x084, target returns 0x0000_1234 with ack -> WB adr=0x3000_0084, we=0, sel=F; rvalid with rdata=0x1234, rresp=00.
3. W given 3 cycles before AW, wstrb=4'b0011 -> no WB cycle until AW is captured; then sel=0011 and bresp=00.
4. Target never acks, TIMEOUT=8 -> cyc drops after 8 cycles; rresp=10, rdata=0; arready returns after the R handshake.
5. Write and read pending in the same cycle, repeated twice -> WB order is write, read, write, read; wbm_err_i on the second write gives bresp=10.
6. Assert reset while cyc=1 and bready held low -> cyc/stb/bvalid are 0 immediately; readies return to 1 one edge after release.

Source files
------------

// File: rtl/axil_wb_pkg.sv
// Shared types and constants for the AXI-Lite to Wishbone bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axil_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_WR,
    WB_RD,
    B_RSP,
    R_RSP
  } state_t;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] DEF_ADDR_BASE = 32'h3000_0000;

endpackage

// File: rtl/axil2wb_master_if.sv
// AXI-Lite slave channels plus Wishbone master signals of the bridge.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on AXI channels, cyc/stb with ack/err on Wishbone.
interface axil2wb_master_if #(
  parameter int AW = 12
);
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic          wvalid;
  logic          wready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic          rvalid;
  logic          rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic [31:0]   wbm_dat_i;
  logic          wbm_ack_i;
  logic          wbm_err_i;

  // Bridge view: it is the Wishbone master that sits behind the AXI-Lite port.
  modport master (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  // Environment view: AXI-Lite initiator plus Wishbone target.
  modport slave (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/axil_hold_reg.sv
// Single-entry capture register for one AXI-Lite request channel.
// Latency: data held from the handshake edge; ready returns one edge after clr.
// Backpressure: ready stays low while an entry is held.
module axil_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] data,
  input  logic         clr,
  output logic         held,
  output logic [W-1:0] q
);

  logic hs;
  assign hs = valid & ready;

  // Capture on handshake, release on clr; ready drops at the capture edge
  // and only comes back one edge after the entry has been released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held  <= 1'b0;
      ready <= 1'b0;
      q     <= '0;
    end else begin
      ready <= !(held | hs);
      if (clr) begin
        held <= 1'b0;
      end else if (hs) begin
        held <= 1'b1;
        q    <= data;
      end
    end
  end

endmodule

// File: rtl/axil2wb_master.sv
// AXI-Lite slave to Wishbone classic master bridge, one transaction at a time.
// Latency: WB cycle starts one edge after the request is held; B/R valid one edge after ack/err/timeout.
// Backpressure: requests are held (ready low) until their B/R response is accepted.
module axil2wb_master
  import axil_wb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter int          AW        = 12,
  parameter int          TIMEOUT   = 255,
  parameter int          TO_W      = 8
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  axil2wb_master_if.master bus
);

  logic          aw_held, w_held, ar_held;
  logic [AW-1:0] aw_q, ar_q;
  logic [35:0]   w_q;
  logic          b_done, r_done;

  axil_hold_reg #(.W(AW)) u_aw (
    .clk(wb_clk_i), .rst(wb_rst_i), .valid(bus.awvalid), .ready(bus.awready),
    .data(bus.awaddr), .clr(b_done), .held(aw_held), .q(aw_q)
  );

  axil_hold_reg #(.W(36)) u_w (
    .clk(wb_clk_i), .rst(wb_rst_i), .valid(bus.wvalid), .ready(bus.wready),
    .data({bus.wstrb, bus.wdata}), .clr(b_done), .held(w_held), .q(w_q)
  );

  axil_hold_reg #(.W(AW)) u_ar (
    .clk(wb_clk_i), .rst(wb_rst_i), .valid(bus.arvalid), .ready(bus.arready),
    .data(bus.araddr), .clr(r_done), .held(ar_held), .q(ar_q)
  );

  state_t          state_q, state_d;
  logic            last_wr_q, last_wr_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            wr_pend, rd_pend, wb_end;
  logic [1:0]      wb_resp;

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.bvalid    = bvalid_q;
  assign bus.bresp     = bresp_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rresp     = rresp_q;
  assign bus.rdata     = rdata_q;

  // Arbitration, Wishbone cycle control and response generation.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    b_done    = 1'b0;
    r_done    = 1'b0;
    wr_pend   = aw_held & w_held;
    rd_pend   = ar_held;
    // Cycle ends on ack, err, or once it has been up for TIMEOUT cycles.
    wb_end    = bus.wbm_ack_i | bus.wbm_err_i | (cnt_q == TO_W'(TIMEOUT - 1));
    // err wins over ack; a timeout (no ack) is also an error.
    wb_resp   = (bus.wbm_err_i | !bus.wbm_ack_i) ? RESP_SLVERR : RESP_OKAY;
    case (state_q)
      IDLE: begin
        // When both are pending, alternate; last_wr resets to "read" so writes go first.
        if (wr_pend && (!rd_pend || !last_wr_q)) begin
          state_d   = WB_WR;
          last_wr_d = 1'b1;
          cyc_d     = 1'b1;
          we_d      = 1'b1;
          sel_d     = w_q[35:32];
          adr_d     = ADDR_BASE | 32'(aw_q);
          dat_d     = w_q[31:0];
          cnt_d     = '0;
        end else if (rd_pend) begin
          state_d   = WB_RD;
          last_wr_d = 1'b0;
          cyc_d     = 1'b1;
          we_d      = 1'b0;
          sel_d     = 4'hF;
          adr_d     = ADDR_BASE | 32'(ar_q);
          dat_d     = w_q[31:0];
          cnt_d     = '0;
        end
      end
      WB_WR: begin
        if (wb_end) begin
          state_d  = B_RSP;
          cyc_d    = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = wb_resp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB_RD: begin
        if (wb_end) begin
          state_d  = R_RSP;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          rresp_d  = wb_resp;
          rdata_d  = (wb_resp == RESP_OKAY) ? bus.wbm_dat_i : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_RSP: begin
        if (bus.bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
          b_done   = 1'b1;
        end
      end
      R_RSP: begin
        if (bus.rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
          rresp_d  = RESP_OKAY;
          rdata_d  = '0;
          r_done   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops cyc/stb immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      cnt_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axil2wb_master.sv
// Bench for axil2wb_master: directed AXI-Lite traffic against a scripted Wishbone target.
// A transaction-level model predicts each WB cycle and its B/R response; one negedge process compares.
// Literal checks after each scenario pin the model to hand-computed values.
module tb_axil2wb_master;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam int          TIMEOUT = 8;
  localparam int          K_ACK   = 0;
  localparam int          K_ERR   = 1;
  localparam int          K_NONE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  axil2wb_master_if #(.AW(12)) bus ();

  axil2wb_master #(.ADDR_BASE(BASE), .AW(12), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          dly;
    int          kind;
    logic [31:0] rd;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  logic wb_log[$];

  logic [31:0] last_adr, last_dat, last_rdata;
  logic [3:0]  last_sel;
  logic        last_we;
  logic [1:0]  last_bresp, last_rresp;
  int          last_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model of one expected Wishbone cycle, built from the request as the initiator sees it.
  function automatic txn_t mk(input logic wr, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int dly, input int kind, input logic [31:0] rd);
    txn_t t;
    t.wr = wr; t.adr = BASE + {20'h0, a}; t.dat = d; t.sel = wr ? s : 4'hF;
    t.dly = dly; t.kind = kind; t.rd = rd;
    return t;
  endfunction

  // ---------------- compare process + scripted Wishbone target ----------------
  logic in_cyc = 1'b0;
  int   ncyc = 0;
  logic pbv, pbr, prv, prr, paw, pw, par;
  logic [1:0]  pbresp, prresp;
  logic [31:0] prdata;
  logic fell, fell_wr;
  logic [1:0] e_resp;

  always @(negedge clk) begin
    if (rst) begin
      in_cyc = 1'b0; bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
      pbv = 0; pbr = 0; prv = 0; prr = 0; paw = 0; pw = 0; par = 0;
    end else begin
      bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
      fell = 1'b0; fell_wr = 1'b0;
      chk("stb_eq_cyc", bus.wbm_stb_o, bus.wbm_cyc_o);
      if (bus.wbm_cyc_o && !in_cyc) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cyc actual=cyc_high required=no_cycle t=%0t", $time);
          cur = mk(bus.wbm_we_o, 12'h0, 32'h0, 4'h0, 0, K_ACK, 32'h0);
        end else begin
          cur = exp_q.pop_front();
        end
        in_cyc = 1'b1; ncyc = 0;
        bus.wbm_dat_i = cur.rd;
        wb_log.push_back(bus.wbm_we_o);
      end
      if (bus.wbm_cyc_o) begin
        chk("wb_adr", bus.wbm_adr_o, cur.adr);
        chk("wb_we", bus.wbm_we_o, cur.wr);
        chk("wb_sel", bus.wbm_sel_o, cur.sel);
        if (cur.wr) chk("wb_dat", bus.wbm_dat_o, cur.dat);
        chk("no_rsp_in_cyc", {bus.bvalid, bus.rvalid}, 0);
        last_adr = bus.wbm_adr_o; last_we = bus.wbm_we_o;
        last_sel = bus.wbm_sel_o; last_dat = bus.wbm_dat_o;
        if (cur.kind != K_NONE && ncyc == cur.dly) begin
          bus.wbm_ack_i = (cur.kind == K_ACK);
          bus.wbm_err_i = (cur.kind == K_ERR);
        end
        ncyc++;
      end else if (in_cyc) begin
        // Cycle just ended: the response must already be up, one edge after ack/err/timeout.
        in_cyc = 1'b0; last_len = ncyc; fell = 1'b1; fell_wr = cur.wr;
        chk("wb_len", ncyc, (cur.kind == K_NONE) ? TIMEOUT : cur.dly + 1);
        e_resp = (cur.kind == K_ACK) ? 2'b00 : 2'b10;
        if (cur.wr) begin
          chk("b_valid", bus.bvalid, 1); chk("b_resp", bus.bresp, e_resp);
          last_bresp = bus.bresp;
        end else begin
          chk("r_valid", bus.rvalid, 1); chk("r_resp", bus.rresp, e_resp);
          chk("r_data", bus.rdata, (cur.kind == K_ACK) ? cur.rd : 32'h0);
          last_rresp = bus.rresp; last_rdata = bus.rdata;
        end
        if (cur.kind == K_NONE) bus.wbm_ack_i = 1'b1;  // late ack, must be ignored
      end
      if (pbv) begin
        chk("b_hold", bus.bvalid, !pbr);
        if (!pbr) chk("b_resp_hold", bus.bresp, pbresp);
      end else if (!(fell && fell_wr)) chk("b_idle", bus.bvalid, 0);
      if (prv) begin
        chk("r_hold", bus.rvalid, !prr);
        if (!prr) chk("r_data_hold", {bus.rresp, bus.rdata}, {prresp, prdata});
      end else if (!(fell && !fell_wr)) chk("r_idle", bus.rvalid, 0);
      if (paw) chk("aw_drop", bus.awready, 0);
      if (pw)  chk("w_drop", bus.wready, 0);
      if (par) chk("ar_drop", bus.arready, 0);
      pbv = bus.bvalid; pbr = bus.bready; pbresp = bus.bresp;
      prv = bus.rvalid; prr = bus.rready; prresp = bus.rresp; prdata = bus.rdata;
      paw = bus.awvalid & bus.awready;
      pw  = bus.wvalid & bus.wready;
      par = bus.arvalid & bus.arready;
    end
  end

  // ---------------- AXI-Lite initiator tasks ----------------
  task automatic tmo(input string name);
    checks++; failures++;
    $display("FAIL %s actual=no_handshake required=handshake_within_100 t=%0t", name, $time);
  endtask

  task automatic send_aw(input logic [11:0] a);
    int n = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    while (!bus.awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("aw_tmo");
    @(posedge clk); #1 bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    while (!bus.wready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("w_tmo");
    @(posedge clk); #1 bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [11:0] a);
    int n = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    while (!bus.arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("ar_tmo");
    @(posedge clk); #1 bus.arvalid = 1'b0;
  endtask

  task automatic recv_b();
    int n = 0;
    while (!bus.bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("b_tmo");
    @(posedge clk); #1 bus.bready = 1'b1;
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask

  task automatic recv_r();
    int n = 0;
    while (!bus.rvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("r_tmo");
    @(posedge clk); #1 bus.rready = 1'b1;
    @(posedge clk); #1 bus.rready = 1'b0;
  endtask

  task automatic check_readies(input string name, input logic [2:0] exp);
    chk(name, {bus.awready, bus.wready, bus.arready}, exp);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
    bus.wbm_dat_i = 0; bus.wbm_ack_i = 0; bus.wbm_err_i = 0;

    // Reset state: everything low, readies rise on the first edge after release.
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                     bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 0);
    chk("rst_sel_resp", {bus.wbm_sel_o, bus.bresp, bus.rresp}, 0);
    chk("rst_adr", bus.wbm_adr_o, 0);
    chk("rst_dat", bus.wbm_dat_o, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    @(negedge clk); check_readies("rel_rdy_low", 3'b000);
    @(negedge clk); check_readies("rel_rdy_up", 3'b111);
    @(posedge clk); #1;

    // 1: write, target acks after 2 cycles.
    exp_q.push_back(mk(1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, 2, K_ACK, 32'h0));
    fork send_aw(12'h010); send_w(32'hDEAD_BEEF, 4'hF); join
    @(negedge clk); chk("t1_cyc_pre", bus.wbm_cyc_o, 0);
    @(negedge clk); chk("t1_cyc_lat", bus.wbm_cyc_o, 1);
    recv_b();
    chk("t1_adr", last_adr, 32'h3000_0010);
    chk("t1_we", last_we, 1);
    chk("t1_sel", last_sel, 4'hF);
    chk("t1_dat", last_dat, 32'hDEAD_BEEF);
    chk("t1_bresp", last_bresp, 2'b00);
    chk("t1_len", last_len, 3);

    // 2: read with data.
    exp_q.push_back(mk(1'b0, 12'h084, 32'h0, 4'h0, 0, K_ACK, 32'h0000_1234));
    send_ar(12'h084);
    recv_r();
    chk("t2_adr", last_adr, 32'h3000_0084);
    chk("t2_we", last_we, 0);
    chk("t2_sel", last_sel, 4'hF);
    chk("t2_rdata", last_rdata, 32'h0000_1234);
    chk("t2_rresp", last_rresp, 2'b00);

    // 3: W three cycles ahead of AW, partial strobes.
    exp_q.push_back(mk(1'b1, 12'h020, 32'hA5A5_5A5A, 4'b0011, 1, K_ACK, 32'h0));
    send_w(32'hA5A5_5A5A, 4'b0011);
    repeat (3) begin @(negedge clk); chk("t3_no_cyc", bus.wbm_cyc_o, 0); end
    @(posedge clk); #1;
    send_aw(12'h020);
    recv_b();
    chk("t3_sel", last_sel, 4'b0011);
    chk("t3_adr", last_adr, 32'h3000_0020);
    chk("t3_bresp", last_bresp, 2'b00);

    // 4: read that never gets an ack -> timeout, SLVERR, zero data.
    exp_q.push_back(mk(1'b0, 12'h100, 32'h0, 4'h0, 0, K_NONE, 32'hFFFF_FFFF));
    send_ar(12'h100);
    recv_r();
    chk("t4_len", last_len, 8);
    chk("t4_rresp", last_rresp, 2'b10);
    chk("t4_rdata", last_rdata, 32'h0);
    @(negedge clk); chk("t4_ar_low", bus.arready, 0);
    @(negedge clk); chk("t4_ar_back", bus.arready, 1);
    @(posedge clk); #1;

    // 5: write and read pending together, twice; second write gets err.
    exp_q.push_back(mk(1'b1, 12'h040, 32'h1111_2222, 4'hF, 0, K_ACK, 32'h0));
    exp_q.push_back(mk(1'b0, 12'h044, 32'h0, 4'h0, 1, K_ACK, 32'hCAFE_0001));
    fork send_aw(12'h040); send_w(32'h1111_2222, 4'hF); send_ar(12'h044); join
    fork recv_b(); recv_r(); join
    chk("t5_bresp1", last_bresp, 2'b00);
    chk("t5_rdata1", last_rdata, 32'hCAFE_0001);
    exp_q.push_back(mk(1'b1, 12'h048, 32'h3333_4444, 4'hF, 0, K_ERR, 32'h0));
    exp_q.push_back(mk(1'b0, 12'h04C, 32'h0, 4'h0, 0, K_ACK, 32'h0000_BEEF));
    fork send_aw(12'h048); send_w(32'h3333_4444, 4'hF); send_ar(12'h04C); join
    fork recv_b(); recv_r(); join
    chk("t5_bresp2", last_bresp, 2'b10);
    chk("t5_rdata2", last_rdata, 32'h0000_BEEF);
    chk("t5_order", {wb_log[4], wb_log[5], wb_log[6], wb_log[7]}, 4'b1010);

    // 6: wstrb=0 write still issued; reset mid-cycle with bready low.
    exp_q.push_back(mk(1'b1, 12'h050, 32'h1234_5678, 4'h0, 0, K_NONE, 32'h0));
    fork send_aw(12'h050); send_w(32'h1234_5678, 4'h0); join
    @(negedge clk);
    @(negedge clk); chk("t6_cyc_up", bus.wbm_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_wb", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.bvalid}, 0);
    check_readies("t6_rst_rdy", 3'b000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); check_readies("t6_rel_low", 3'b000);
    @(negedge clk); check_readies("t6_rel_up", 3'b111);
    repeat (20) @(negedge clk);
    chk("t6_idle", {bus.wbm_cyc_o, bus.bvalid, bus.rvalid}, 0);
    chk("exp_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still_running required=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
